// File: rtl/fp_norm_pkg.sv
// Shared definitions for the iterative post-add normalizer: default widths,
// the nibble step size and the control state encoding.
package fp_norm_pkg;

  localparam int unsigned SIZE_MANTISSA = 23;
  localparam int unsigned SIZE_EXPONENT = 8;
  localparam int unsigned NIBBLE        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fp_iterative_normalizer_if.sv
// Operand/result handshake bundle between the significand adder, the
// normalizer (slave) and the rounder.
interface fp_iterative_normalizer_if
  import fp_norm_pkg::*;
#(
  parameter int unsigned SizeMantissa = SIZE_MANTISSA,
  parameter int unsigned SizeExponent = SIZE_EXPONENT
);
  localparam int unsigned ShiftW = $clog2(SizeMantissa + 2);

  logic                    valid_i;
  logic                    ready_o;
  logic [SizeMantissa+1:0] mantissa_i;
  logic [SizeExponent-1:0] exponent_i;
  logic                    valid_o;
  logic                    ready_i;
  logic [SizeMantissa:0]   mantissa_o;
  logic [SizeExponent-1:0] exponent_o;
  logic [ShiftW-1:0]       shift_o;
  logic                    right_o;
  logic                    sticky_o;
  logic                    zero_o;
  logic                    overflow_o;

  modport slave (
    input  valid_i, mantissa_i, exponent_i, ready_i,
    output ready_o, valid_o, mantissa_o, exponent_o, shift_o,
           right_o, sticky_o, zero_o, overflow_o
  );

  modport master (
    output valid_i, mantissa_i, exponent_i, ready_i,
    input  ready_o, valid_o, mantissa_o, exponent_o, shift_o,
           right_o, sticky_o, zero_o, overflow_o
  );

endinterface

// File: rtl/fp_norm_step.sv
// One normalization step: decides, in priority order, whether the working
// value is finished or needs a carry right shift, a nibble or a single left shift.
module fp_norm_step
  import fp_norm_pkg::*;
#(
  parameter int unsigned SizeMantissa = SIZE_MANTISSA,
  parameter int unsigned SizeExponent = SIZE_EXPONENT,
  localparam int unsigned ShiftW      = $clog2(SizeMantissa + 2)
) (
  input  logic [SizeMantissa+1:0] mant_i,
  input  logic [SizeExponent-1:0] exp_i,
  output logic [SizeMantissa+1:0] mant_o,
  output logic [SizeExponent-1:0] exp_o,
  output logic [ShiftW-1:0]       amt_o,
  output logic                    done_o,
  output logic                    right_o,
  output logic                    sticky_o,
  output logic                    zero_o,
  output logic                    overflow_o
);

  localparam logic [SizeExponent-1:0] ExpOne    = SizeExponent'(1);
  localparam logic [SizeExponent-1:0] ExpNibble = SizeExponent'(NIBBLE);

  logic [SizeExponent-1:0] exp_inc;
  assign exp_inc = exp_i + ExpOne;

  always_comb begin
    // NOTE: every output gets a default first so no path through the
    // priority chain leaves a value unassigned and infers a latch.
    mant_o     = mant_i;
    exp_o      = exp_i;
    amt_o      = '0;
    done_o     = 1'b0;
    right_o    = 1'b0;
    sticky_o   = 1'b0;
    zero_o     = 1'b0;
    overflow_o = 1'b0;
    if (mant_i == '0) begin
      exp_o  = '0;
      zero_o = 1'b1;
      done_o = 1'b1;
    end else if (&exp_i) begin
      done_o = 1'b1;
    end else if (mant_i[SizeMantissa+1]) begin
      mant_o   = mant_i >> 1;
      sticky_o = mant_i[0];
      exp_o    = exp_inc;
      right_o  = 1'b1;
      done_o   = 1'b1;
      if (&exp_inc) begin
        mant_o     = '0;
        overflow_o = 1'b1;
      end
    end else if (mant_i[SizeMantissa]) begin
      done_o = 1'b1;
    end else if (exp_i == ExpOne) begin
      exp_o  = '0;
      done_o = 1'b1;
    end else if (mant_i[SizeMantissa -: NIBBLE] == '0 && exp_i > ExpNibble) begin
      // Nibble steps only while the exponent can absorb all four positions.
      mant_o = mant_i << NIBBLE;
      exp_o  = exp_i - ExpNibble;
      amt_o  = ShiftW'(NIBBLE);
    end else begin
      mant_o = mant_i << 1;
      exp_o  = exp_i - ExpOne;
      amt_o  = ShiftW'(1);
    end
  end

endmodule

// File: rtl/fp_iterative_normalizer.sv
// Multi-cycle post-add normalizer: accepts one raw sum, iterates fp_norm_step
// until normalized, then holds the registered result until downstream takes it.
module fp_iterative_normalizer
  import fp_norm_pkg::*;
#(
  parameter int unsigned SizeMantissa = SIZE_MANTISSA,
  parameter int unsigned SizeExponent = SIZE_EXPONENT
) (
  input logic                      clk,
  input logic                      reset,
  fp_iterative_normalizer_if.slave bus
);

  localparam int unsigned ShiftW = $clog2(SizeMantissa + 2);

  state_e                  state_q, state_d;
  logic [SizeMantissa+1:0] mant_q, mant_d;
  logic [SizeExponent-1:0] exp_q, exp_d;
  logic [ShiftW-1:0]       shift_q, shift_d;
  logic                    right_q, right_d;
  logic                    sticky_q, sticky_d;
  logic                    zero_q, zero_d;
  logic                    ovf_q, ovf_d;

  logic [SizeMantissa+1:0] step_mant;
  logic [SizeExponent-1:0] step_exp;
  logic [ShiftW-1:0]       step_amt;
  logic                    step_done, step_right, step_sticky, step_zero, step_ovf;

  fp_norm_step #(
    .SizeMantissa(SizeMantissa),
    .SizeExponent(SizeExponent)
  ) u_step (
    .mant_i    (mant_q),
    .exp_i     (exp_q),
    .mant_o    (step_mant),
    .exp_o     (step_exp),
    .amt_o     (step_amt),
    .done_o    (step_done),
    .right_o   (step_right),
    .sticky_o  (step_sticky),
    .zero_o    (step_zero),
    .overflow_o(step_ovf)
  );

  always_comb begin
    state_d  = state_q;
    mant_d   = mant_q;
    exp_d    = exp_q;
    shift_d  = shift_q;
    right_d  = right_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid_i) begin
          state_d  = ST_NORM;
          mant_d   = bus.mantissa_i;
          // A biased exponent of 0 carries the same scale as exponent 1.
          exp_d    = (bus.exponent_i == '0) ? SizeExponent'(1) : bus.exponent_i;
          shift_d  = '0;
          right_d  = 1'b0;
          sticky_d = 1'b0;
          zero_d   = 1'b0;
          ovf_d    = 1'b0;
        end
      end
      ST_NORM: begin
        mant_d   = step_mant;
        exp_d    = step_exp;
        shift_d  = shift_q + step_amt;
        right_d  = step_right;
        sticky_d = step_sticky;
        zero_d   = step_zero;
        ovf_d    = step_ovf;
        if (step_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mant_q   <= '0;
      exp_q    <= '0;
      shift_q  <= '0;
      right_q  <= 1'b0;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mant_q   <= mant_d;
      exp_q    <= exp_d;
      shift_q  <= shift_d;
      right_q  <= right_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.ready_o    = (state_q == ST_IDLE);
  assign bus.valid_o    = (state_q == ST_DONE);
  assign bus.mantissa_o = mant_q[SizeMantissa:0];
  assign bus.exponent_o = exp_q;
  assign bus.shift_o    = shift_q;
  assign bus.right_o    = right_q;
  assign bus.sticky_o   = sticky_q;
  assign bus.zero_o     = zero_q;
  assign bus.overflow_o = ovf_q;

endmodule

// File: tb/tb_fp_iterative_normalizer.sv
// Self-checking bench for fp_iterative_normalizer: vector table with a
// scoreboard queue, plus reset, mid-NORM reset and backpressure sequences.
module tb_fp_iterative_normalizer;
  import fp_norm_pkg::*;

  typedef struct {
    logic [24:0] mant;
    logic [7:0]  exp;
    logic [23:0] e_mant;
    logic [7:0]  e_exp;
    logic [4:0]  e_shift;
    logic [3:0]  e_flags;  // {right, sticky, zero, overflow}
    int          e_lat;    // cycles from accept cycle to valid_o
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  fp_iterative_normalizer_if bus ();

  fp_iterative_normalizer dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_err = 0;
  vec_t sb_q[$];
  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {bus.right_o, bus.sticky_o, bus.zero_o, bus.overflow_o};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready_o) check("ready_wait", 32'(bus.ready_o), 32'd1);
  endtask

  // Drive one operand, scoreboard the expectation, wait for the result.
  task automatic apply(input vec_t v, input string tag);
    int   cyc;
    vec_t e;
    wait_ready();
    bus.valid_i    = 1'b1;
    bus.mantissa_i = v.mant;
    bus.exponent_i = v.exp;
    @(posedge clk);
    sb_q.push_back(v);
    @(negedge clk);
    bus.valid_i = 1'b0;
    cyc = 1;
    while (!bus.valid_o && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    e = sb_q.pop_front();
    check({tag, "_lat"}, 32'(cyc), 32'(e.e_lat));
    check({tag, "_mant"}, 32'(bus.mantissa_o), 32'(e.e_mant));
    check({tag, "_exp"}, 32'(bus.exponent_o), 32'(e.e_exp));
    check({tag, "_shift"}, 32'(bus.shift_o), 32'(e.e_shift));
    check({tag, "_flags"}, 32'(flags()), 32'(e.e_flags));
    if (!bus.valid_o) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end else begin
      bus.ready_i = 1'b1;
      @(negedge clk);
      bus.ready_i = 1'b0;
      check({tag, "_release"}, 32'({bus.ready_o, bus.valid_o}), 32'b10);
    end
  endtask

  initial begin
    int   cyc;
    logic seen_valid;
    vec_t zv;

    vecs[0]  = '{25'h0800000, 8'd127, 24'h800000, 8'd127, 5'd0,  4'b0000, 2};
    vecs[1]  = '{25'h1800001, 8'd127, 24'hC00000, 8'd128, 5'd0,  4'b1100, 2};
    vecs[2]  = '{25'h1800001, 8'd254, 24'h000000, 8'd255, 5'd0,  4'b1101, 2};
    vecs[3]  = '{25'h0040000, 8'd127, 24'h800000, 8'd122, 5'd5,  4'b0000, 4};
    vecs[4]  = '{25'h0000100, 8'd3,   24'h000400, 8'd0,   5'd2,  4'b0000, 4};
    vecs[5]  = '{25'h0C00000, 8'd255, 24'hC00000, 8'd255, 5'd0,  4'b0000, 2};
    vecs[6]  = '{25'h0000001, 8'd0,   24'h000001, 8'd0,   5'd0,  4'b0000, 2};
    vecs[7]  = '{25'h0000001, 8'd127, 24'h800000, 8'd104, 5'd23, 4'b0000, 10};
    vecs[8]  = '{25'h1000002, 8'd10,  24'h800001, 8'd11,  5'd0,  4'b1000, 2};
    vecs[9]  = '{25'h0000010, 8'd6,   24'h000200, 8'd0,   5'd5,  4'b0000, 4};
    vecs[10] = '{25'h0080000, 8'd5,   24'h800000, 8'd1,   5'd4,  4'b0000, 3};
    vecs[11] = '{25'h0080000, 8'd4,   24'h400000, 8'd0,   5'd3,  4'b0000, 5};

    reset          = 1'b1;
    bus.valid_i    = 1'b0;
    bus.ready_i    = 1'b0;
    bus.mantissa_i = '0;
    bus.exponent_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_hs", 32'({bus.ready_o, bus.valid_o}), 32'b10);
    check("rst_data", 32'({bus.exponent_o, bus.mantissa_o}), 32'd0);
    check("rst_misc", 32'({bus.shift_o, flags()}), 32'd0);

    for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset while shifting: the operand is dropped and no result appears.
    wait_ready();
    bus.valid_i    = 1'b1;
    bus.mantissa_i = 25'h0000001;
    bus.exponent_i = 8'd127;
    @(negedge clk);
    bus.valid_i = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_hs", 32'({bus.ready_o, bus.valid_o}), 32'b10);
    check("midrst_data", 32'({bus.exponent_o, bus.mantissa_o}), 32'd0);
    check("midrst_misc", 32'({bus.shift_o, flags()}), 32'd0);
    seen_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      seen_valid |= bus.valid_o;
    end
    check("midrst_novalid", 32'(seen_valid), 32'd0);

    // Zero operand followed by backpressure with a competing valid_i.
    zv = '{25'h0000000, 8'd50, 24'h000000, 8'd0, 5'd0, 4'b0010, 2};
    wait_ready();
    bus.valid_i    = 1'b1;
    bus.mantissa_i = zv.mant;
    bus.exponent_i = zv.exp;
    @(posedge clk);
    sb_q.push_back(zv);
    @(negedge clk);
    bus.mantissa_i = 25'h0800000;
    bus.exponent_i = 8'd9;
    cyc = 1;
    while (!bus.valid_o && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    zv = sb_q.pop_front();
    check("zero_lat", 32'(cyc), 32'(zv.e_lat));
    check("zero_flags", 32'(flags()), 32'(zv.e_flags));
    check("zero_exp", 32'(bus.exponent_o), 32'(zv.e_exp));
    repeat (3) begin
      @(negedge clk);
      check("bp_state", 32'({bus.valid_o, bus.ready_o, flags()}), 32'({2'b10, 4'b0010}));
      check("bp_data", 32'({bus.exponent_o, bus.mantissa_o}), 32'd0);
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    @(negedge clk);
    bus.ready_i = 1'b0;
    check("bp_release", 32'({bus.ready_o, bus.valid_o}), 32'b10);
    seen_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen_valid |= bus.valid_o;
    end
    check("bp_ignored", 32'(seen_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
